// File: rtl/booth_pkg.sv
// booth_pkg
// Shared definitions for the radix-2 Booth multiplier datapath and its
// controller decoder:
//   WIDTH_DEFAULT - default signed operand width
//   booth_op_e    - add/subtract/no-op selection derived from the Booth pair
//   ctrl_state_e  - controller state codes used by the strobe decoder
//   booth_decode  - maps the Booth pair {Q[0], Q(-1)} to an operation
package booth_pkg;

    localparam int WIDTH_DEFAULT = 24;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } booth_op_e;

    typedef enum logic [2:0] {
        S_RESET = 3'b000,
        S_LOAD  = 3'b001,
        S_STEP  = 3'b010,
        S_DONE  = 3'b011
    } ctrl_state_e;

    // Pair 01 ends a run of ones (add M), pair 10 starts one (subtract M).
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        case (pair)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// booth_addsub
// Combinational W-bit adder/subtractor for one Booth iteration.
// Ports:
//   a   in  W  accumulator operand (A, already one bit wider than M)
//   b   in  W  sign-extended multiplicand
//   op  in     Booth operation (OP_ADD, OP_SUB, OP_NOP passes a through)
//   sum out W  a + b, a - b or a
module booth_addsub
    import booth_pkg::*;
#(
    parameter int W = WIDTH_DEFAULT + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  booth_op_e    op,
    output logic [W-1:0] sum
);

    always_comb begin
        sum = a;
        case (op)
            OP_ADD:  sum = a + b;
            OP_SUB:  sum = a - b;
            default: sum = a;
        endcase
    end

endmodule

// File: rtl/booth_datapath.sv
// booth_datapath
// Register datapath of the radix-2 Booth multiplier: A (WIDTH+1 bits), M, Q,
// Q(-1), the iteration counter and the registered product.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   reset                      functional clear from the controller
//   load, rwe_M, rwe_Q         operand load strobe and operand write enables
//   rwe_A, rwe_Qlessbit        with rwe_Q, all three high request one step
//   out_res_A_e, out_res_Q_e,  all three high capture {A, Q} into result
//   done
//   multiplicand_in            operand for M
//   multiplier_in              operand for Q
//   q_pair                     Booth pair {Q[0], Q(-1)} to the controller
//   count_zero                 iteration counter is zero
//   result                     registered signed product (2*WIDTH bits)
//   result_valid               one-cycle pulse after a capture
//
// result_valid has no ready: it is a single-cycle pulse in the cycle after a
// capture and result stays stable until the next clear or capture.
// Update priority: clear, load, step, capture.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 rwe_M,
    input  logic                 rwe_Q,
    input  logic                 rwe_A,
    input  logic                 rwe_Qlessbit,
    input  logic                 out_res_A_e,
    input  logic                 out_res_Q_e,
    input  logic                 done,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    output logic [1:0]           q_pair,
    output logic                 count_zero,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    logic [WIDTH:0]       a_q;
    logic [WIDTH:0]       a_sum;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     q_q;
    logic                 qm1_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 result_valid_q;

    logic                 step_req;
    logic                 capture_req;
    booth_op_e            op;

    assign step_req    = rwe_A & rwe_Q & rwe_Qlessbit;
    assign capture_req = out_res_A_e & out_res_Q_e & done;
    assign op          = booth_decode({q_q[0], qm1_q});

    // A carries one extra bit so that A - M cannot overflow, which keeps the
    // (-2^(WIDTH-1))^2 corner exact.
    booth_addsub #(
        .W (WIDTH + 1)
    ) u_addsub (
        .a   (a_q),
        .b   ({m_q[WIDTH-1], m_q}),
        .op  (op),
        .sum (a_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || reset) begin
            a_q            <= '0;
            m_q            <= '0;
            q_q            <= '0;
            qm1_q          <= 1'b0;
            cnt_q          <= CNT_INIT;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else if (load) begin
            if (rwe_M) m_q <= multiplicand_in;
            if (rwe_Q) q_q <= multiplier_in;
            a_q            <= '0;
            qm1_q          <= 1'b0;
            cnt_q          <= CNT_INIT;
            result_valid_q <= 1'b0;
        end else if (step_req) begin
            // A step request outranks capture even when the counter has
            // expired; in that case every register simply holds.
            if (cnt_q != '0) begin
                // Arithmetic right shift of {A', Q, Q(-1)}.
                a_q   <= {a_sum[WIDTH], a_sum[WIDTH:1]};
                q_q   <= {a_sum[0], q_q[WIDTH-1:1]};
                qm1_q <= q_q[0];
                cnt_q <= cnt_q - CW'(1);
            end
            result_valid_q <= 1'b0;
        end else if (capture_req) begin
            result_q       <= {a_q[WIDTH-1:0], q_q};
            result_valid_q <= 1'b1;
        end else begin
            result_valid_q <= 1'b0;
        end
    end

    assign q_pair       = {q_q[0], qm1_q};
    assign count_zero   = (cnt_q == '0);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_booth_datapath.sv
// tb_booth_datapath
// Self-checking bench for booth_datapath at WIDTH=8. The reference keeps the
// operation at the level of "operands, steps taken, product": q_pair and
// count_zero follow from the multiplier bits and the step count, result from
// a plain signed multiply.
module tb_booth_datapath;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0;
    logic           reset = 1'b0;
    logic           load = 1'b0;
    logic           rwe_M = 1'b0;
    logic           rwe_Q = 1'b0;
    logic           rwe_A = 1'b0;
    logic           rwe_Qlessbit = 1'b0;
    logic           out_res_A_e = 1'b0;
    logic           out_res_Q_e = 1'b0;
    logic           done = 1'b0;
    logic [W-1:0]   multiplicand_in = '0;
    logic [W-1:0]   multiplier_in = '0;
    logic [1:0]     q_pair;
    logic           count_zero;
    logic [2*W-1:0] result;
    logic           result_valid;

    booth_datapath #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .reset           (reset),
        .load            (load),
        .rwe_M           (rwe_M),
        .rwe_Q           (rwe_Q),
        .rwe_A           (rwe_A),
        .rwe_Qlessbit    (rwe_Qlessbit),
        .out_res_A_e     (out_res_A_e),
        .out_res_Q_e     (out_res_Q_e),
        .done            (done),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .q_pair          (q_pair),
        .count_zero      (count_zero),
        .result          (result),
        .result_valid    (result_valid)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] prod16(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[2*W-1:0];
    endfunction

    // After k steps Q has shifted right k places: Q[0] is multiplier bit k
    // (or product bit 0 once all bits are consumed) and Q(-1) is bit k-1.
    function automatic logic [1:0] exp_qpair(input logic [W-1:0] mc, input logic [W-1:0] mp, input int k);
        logic [2*W-1:0] p;
        logic b1;
        logic b0;
        p  = prod16(mc, mp);
        b1 = (k < W) ? mp[k] : p[0];
        b0 = (k == 0) ? 1'b0 : mp[k-1];
        return {b1, b0};
    endfunction

    // ---------------- behavioural model ----------------
    logic [W-1:0]   m_mc = '0;
    logic [W-1:0]   m_mp = '0;
    int             m_k = 0;
    logic [2*W-1:0] m_res = '0;
    logic           m_rv = 1'b0;
    logic           started = 1'b0;
    int             cyc = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
        if (!rst_n || reset) begin
            m_mc  <= '0;
            m_mp  <= '0;
            m_k   <= 0;
            m_res <= '0;
            m_rv  <= 1'b0;
        end else if (load) begin
            if (rwe_M) m_mc <= multiplicand_in;
            if (rwe_Q) m_mp <= multiplier_in;
            m_k  <= 0;
            m_rv <= 1'b0;
        end else if (rwe_A && rwe_Q && rwe_Qlessbit) begin
            if (m_k < W) m_k <= m_k + 1;
            m_rv <= 1'b0;
        end else if (out_res_A_e && out_res_Q_e && done) begin
            m_res <= prod16(m_mc, m_mp);
            m_rv  <= 1'b1;
        end else begin
            m_rv <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("q_pair", 32'(q_pair), 32'(exp_qpair(m_mc, m_mp, m_k)));
            check("count_zero", 32'(count_zero), 32'(m_k == W));
            check("result", 32'(result), 32'(m_res));
            check("result_valid", 32'(result_valid), 32'(m_rv));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit ld, input bit m, input bit q, input bit a, input bit ql,
                         input bit cap, input bit dn, input logic [W-1:0] mc, input logic [W-1:0] mp);
        @(negedge clk);
        load            = ld;
        rwe_M           = m;
        rwe_Q           = q;
        rwe_A           = a;
        rwe_Qlessbit    = ql;
        out_res_A_e     = cap;
        out_res_Q_e     = cap;
        done            = dn;
        multiplicand_in = mc;
        multiplier_in   = mp;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic step();
        drive(0, 0, 1, 1, 1, 0, 0, '0, '0);
    endtask

    // Load, WIDTH steps (with optional stall cycles), optional extra step
    // requests, one decision cycle, capture, then wait for result_valid.
    task automatic run_mult(input logic [W-1:0] mc, input logic [W-1:0] mp, input bit load_m,
                            input int stall_pct, input int extra, input bit ld_step,
                            output logic [2*W-1:0] res, output int lat);
        int steps;
        int ld_cyc;
        bit seen;
        drive(1, load_m, 1, ld_step, ld_step, 0, 0, mc, mp);
        ld_cyc = cyc + 1;
        steps = 0;
        while (steps < W) begin
            if ($urandom_range(0, 99) < stall_pct) begin
                int r;
                r = $urandom_range(0, 6);
                drive(0, 0, r[1], r[0], r[2], 1'($urandom_range(0, 1)), 0, '0, '0);
            end else begin
                step();
                steps++;
            end
        end
        repeat (extra) step();
        idle();
        drive(0, 0, 0, 0, 0, 1, 1, '0, '0);
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 6 && !seen; i++) begin
            idle();
            if (result_valid === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - ld_cyc;
            end
        end
        check("rv_seen", 32'(seen), 32'd1);
        res = result;
    endtask

    // ---------------- stimulus ----------------
    logic [2*W-1:0] res;
    int             lat;

    initial begin
        idle();
        idle();
        check("reset_q_pair", 32'(q_pair), 32'd0);
        check("reset_count_zero", 32'(count_zero), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_rv", 32'(result_valid), 32'd0);
        rst_n = 1'b1;
        idle();

        // Basic product and latency
        run_mult(8'd7, 8'd3, 1, 0, 0, 0, res, lat);
        check("7x3", 32'(res), 32'h0015);
        check("7x3_latency", 32'(lat), 32'd10);

        run_mult(8'hFB, 8'd6, 1, 0, 0, 0, res, lat);
        check("m5x6", 32'(res), 32'hFFE2);
        run_mult(8'h80, 8'h80, 1, 0, 0, 0, res, lat);
        check("m128xm128", 32'(res), 32'h4000);
        run_mult(8'h80, 8'h7F, 1, 0, 0, 0, res, lat);
        check("m128x127", 32'(res), 32'hC080);

        // Step requests held after the counter expires
        run_mult(8'd7, 8'd3, 1, 0, 4, 0, res, lat);
        check("held_steps", 32'(res), 32'h0015);
        check("held_count_zero", 32'(count_zero), 32'd1);

        // Functional clear in the middle of an operation
        drive(1, 1, 1, 0, 0, 0, 0, 8'd7, 8'd3);
        step();
        step();
        step();
        step();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check("abort_q_pair", 32'(q_pair), 32'd0);
        check("abort_count_zero", 32'(count_zero), 32'd0);
        repeat (3) idle();
        run_mult(8'd2, 8'd2, 1, 0, 0, 0, res, lat);
        check("2x2_after_abort", 32'(res), 32'h0004);

        // rst_n wins over load: M stays cleared, so a Q-only reload gives 0
        drive(1, 1, 1, 0, 0, 0, 0, 8'h55, 8'h33);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        check("rstn_load_q_pair", 32'(q_pair), 32'd0);
        run_mult(8'h44, 8'd5, 0, 0, 0, 0, res, lat);
        check("m_cleared", 32'(res), 32'h0000);

        // Load together with a step request
        run_mult(8'h0B, 8'hF3, 1, 0, 0, 1, res, lat);
        check("load_with_step", 32'(res), 32'hFF71);

        // Partial enables hold, capture without done is ignored
        repeat (5) drive(0, 0, 0, 1, 0, 0, 0, '0, '0);
        drive(0, 0, 0, 0, 0, 1, 0, '0, '0);
        drive(0, 0, 0, 0, 0, 1, 0, '0, '0);
        idle();
        check("no_done_result", 32'(result), 32'hFF71);
        check("no_done_rv", 32'(result_valid), 32'd0);

        // Randomized operands with stalls
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            if (n == 0) a = 8'h7F;
            if (n == 1) b = 8'h80;
            run_mult(a, b, 1, 30, $urandom_range(0, 2), 1'($urandom_range(0, 1)), res, lat);
            check("random_product", 32'(res), 32'(prod16(a, b)));
        end

        idle();
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
